simon64_128_decrypt: RTL and testbench
======================================

# simon64_128_decrypt

Iterative SIMON 64/128 decryption core: the inverse of the encryption round datapath. Accepts a 64-bit ciphertext and 128-bit key via valid/ready, expands the 44 round keys into an internal register file, then applies 44 inverse rounds, one per clock, using keys k43 down to k0. Sits beside the encryption core and presents the same word ordering, so a ciphertext from the encryptor decrypts bit-exactly.

## Interface
- WIDTH, 32, word width; fixed for 64/128 and not to be overridden.
- ROUNDS, 44, number of rounds.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  ciphertext/key offered.
- o_ready  out  1  core can accept; high only in IDLE.
- i_data  in  [0:2*WIDTH-1]  ciphertext {x,y}; bit 0 is MSB of x.
- i_key  in  [0:4*WIDTH-1]  key {k3,k2,k1,k0}; bit 0 is MSB of k3.
- i_rekey  in  1  expand i_key; used only with SIMON_DEC_KEY_CACHE_EN.
- o_valid  out  1  plaintext available.
- i_ready  in  1  consumer accepts plaintext.
- o_data  out  [0:2*WIDTH-1]  plaintext {x,y}; held stable while o_valid=1.

## Operation
- States: IDLE, EXPAND, ROUND, DONE.
- IDLE: o_ready=1. On i_valid&o_ready:
  - capture i_data into {x,y};
  - write k0..k3 from i_key;
  - go to EXPAND, counter i=0.
- EXPAND, once per cycle, i=0..39:
  - t = (k[i+3]>>>3) ^ k[i+1];
  - k[i+4] = 0xFFFFFFFC ^ z3[i] ^ k[i] ^ t ^ (t>>>1);
  - z3 = 11011011101011000110010111100000010010001010011100110100001111, bit i counted from the left.
  - After i=39, go to ROUND with r=43.
- ROUND, once per cycle, r=43..0:
  - x_new = y;
  - y_new = x ^ f(y) ^ k[r];
  - f(v) = ((v<<<1) & (v<<<8)) ^ (v<<<2).
  - All rotations are 32-bit circular; there are no carries.
  - After r=0, go to DONE.
- DONE: o_valid=1, o_data={x,y}. On i_ready, go to IDLE.
- i_valid is ignored outside IDLE, and i_ready is ignored outside DONE.
- Inputs are sampled only on the accept edge. Later changes to i_data or i_key have no effect.

## Timing
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_data=0, counters=0, key file contents don't-care (cache valid flag cleared).
- Latency from accept edge to o_valid high:
  - 84 cycles with key expansion (40 EXPAND + 44 ROUND);
  - 44 cycles when expansion is skipped.
- DONE to IDLE takes one edge after i_ready is high. The next accept can happen on the following edge, giving one idle cycle minimum between blocks.
- Back-pressure: DONE persists indefinitely while i_ready=0, with o_data unchanged.
- Reset asserted mid-EXPAND, mid-ROUND or mid-DONE:
  - operation aborts immediately and nothing is output;
  - the cache is invalidated;
  - the core returns to IDLE.
- o_ready and o_valid are decoded from registered state and are never both high.

## Configuration
- SIMON_DEC_KEY_CACHE_EN undefined:
  - every accepted block expands its key (84-cycle latency);
  - i_rekey is ignored.
- SIMON_DEC_KEY_CACHE_EN defined:
  - a key-valid flag is kept alongside the round-key file;
  - on accept with i_rekey=0 and flag set, i_key is ignored and the core goes straight to ROUND (44 cycles);
  - with i_rekey=1, or with the flag clear, the core loads and expands i_key (84 cycles) and sets the flag at the end of EXPAND;
  - reset clears the flag.

## Structure
- Shared package simon_pkg holds:
  - WORD=32, ROUNDS=44, KEY_WORDS=4;
  - C_CONST=32'hFFFFFFFC;
  - the 62-bit Z3 sequence;
  - the state enum, also used by the encryption core.
- One combinational sub-module, simon_inv_round:
  - inputs x, y, round key; output next {x,y};
  - instantiated once.
- Key expansion stays inline. The round-key file is a 44x32 register array indexed by the counter.

## Test plan
- Standard vector: key 1b1a1918_13121110_0b0a0908_03020100, ciphertext 44c8fc20_b9dfa07a -> o_data 656b696c_20646e75, o_valid exactly 84 cycles after accept.
- Loopback: 1000 random key/plaintext pairs encrypted by the encryption core then decrypted -> plaintext recovered every time; o_ready low throughout each operation.
- Back-pressure: hold i_ready=0 for 20 cycles in DONE -> o_data and o_valid stable, i_valid pulses ignored; release -> IDLE next edge.
- Reset at cycle 30 of EXPAND and at cycle 20 of ROUND -> o_valid never asserts; o_ready=1 immediately; next standard vector decrypts correctly in 84 cycles.
- SIMON_DEC_KEY_CACHE_EN defined:
  - first block with i_rekey=0 after reset -> expands, 84 cycles;
  - second block with the same key, i_rekey=0 and i_key driven to 0 -> correct plaintext in 44 cycles;
  - i_rekey=1 with a new key -> 84 cycles, correct.
- Zero vector: key 0, ciphertext 0 -> output matches the software model; o_data returns 0 after reset.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared SIMON 64/128 constants, FSM state type and rotate helpers,
// common to the encryption and decryption cores.
package simon_pkg;

    localparam int WORD      = 32;
    localparam int ROUNDS    = 44;
    localparam int KEY_WORDS = 4;
    localparam int EXP_STEPS = ROUNDS - KEY_WORDS;

    localparam logic [WORD-1:0] C_CONST = 32'hFFFFFFFC;
    // Bit 61 is the first (leftmost) element of the z3 sequence.
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } simon_state_e;

    function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] v, input int n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] v, input int n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic logic z3_bit(input logic [5:0] i);
        return Z3[6'd61 - i];
    endfunction

endpackage

// File: rtl/simon_inv_round.sv
// One SIMON inverse round: (x, y) -> (y, x ^ f(y) ^ k).
module simon_inv_round
    import simon_pkg::*;
(
    input  logic [WORD-1:0] x_i,
    input  logic [WORD-1:0] y_i,
    input  logic [WORD-1:0] k_i,
    output logic [WORD-1:0] x_o,
    output logic [WORD-1:0] y_o
);

    logic [WORD-1:0] f_y;

    assign f_y = (rotl(y_i, 1) & rotl(y_i, 8)) ^ rotl(y_i, 2);
    assign x_o = y_i;
    assign y_o = x_i ^ f_y ^ k_i;

endmodule

// File: rtl/simon64_128_decrypt.sv
// Iterative SIMON 64/128 decryption core: key expansion then 44 inverse rounds.
// Optional round-key reuse across blocks is enabled by SIMON_DEC_KEY_CACHE_EN.
module simon64_128_decrypt
    import simon_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [0:2*WORD-1]             i_data,
    input  logic [0:KEY_WORDS*WORD-1]     i_key,
    input  logic                          i_rekey,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [0:2*WORD-1]             o_data
);

    simon_state_e    state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [WORD-1:0] x_q, x_d, y_q, y_d;
    logic [WORD-1:0] rk_q [ROUNDS];
    logic [WORD-1:0] key_w [KEY_WORDS];

    logic            key_load;
    logic            key_exp;
    logic            hit;
    logic [WORD-1:0] exp_t, exp_word;
    logic [WORD-1:0] rnd_k, rnd_x, rnd_y;

    // i_key arrives as {k3,k2,k1,k0} with k3 in the leftmost bits.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key_split
            assign key_w[gi] = i_key[(KEY_WORDS-1-gi)*WORD +: WORD];
        end
    endgenerate

`ifdef SIMON_DEC_KEY_CACHE_EN
    logic kv_q, kv_d;

    assign hit = kv_q & ~i_rekey;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            kv_q <= 1'b0;
        end else begin
            kv_q <= kv_d;
        end
    end
`else
    logic unused_rekey;

    assign unused_rekey = i_rekey;
    assign hit          = 1'b0;
`endif

    assign exp_t    = rotr(rk_q[cnt_q + 6'd3], 3) ^ rk_q[cnt_q + 6'd1];
    assign exp_word = C_CONST ^ {{(WORD-1){1'b0}}, z3_bit(cnt_q)} ^ rk_q[cnt_q]
                    ^ exp_t ^ rotr(exp_t, 1);
    assign rnd_k    = rk_q[cnt_q];

    simon_inv_round u_round (
        .x_i (x_q),
        .y_i (y_q),
        .k_i (rnd_k),
        .x_o (rnd_x),
        .y_o (rnd_y)
    );

    // Round-key file has no reset; its contents are qualified by the FSM (and cache flag).
    always_ff @(posedge i_clk) begin
        if (key_load) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                rk_q[k] <= key_w[k];
            end
        end
        if (key_exp) begin
            rk_q[cnt_q + 6'd4] <= exp_word;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        key_load = 1'b0;
        key_exp  = 1'b0;
`ifdef SIMON_DEC_KEY_CACHE_EN
        kv_d     = kv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    x_d = i_data[0:WORD-1];
                    y_d = i_data[WORD:2*WORD-1];
                    if (hit) begin
                        state_d = ST_ROUND;
                        cnt_d   = 6'(ROUNDS - 1);
                    end else begin
                        key_load = 1'b1;
                        state_d  = ST_EXPAND;
                        cnt_d    = '0;
`ifdef SIMON_DEC_KEY_CACHE_EN
                        kv_d     = 1'b0;
`endif
                    end
                end
            end
            ST_EXPAND: begin
                key_exp = 1'b1;
                if (cnt_q == 6'(EXP_STEPS - 1)) begin
                    state_d = ST_ROUND;
                    cnt_d   = 6'(ROUNDS - 1);
`ifdef SIMON_DEC_KEY_CACHE_EN
                    kv_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_ROUND: begin
                x_d = rnd_x;
                y_d = rnd_y;
                if (cnt_q == 6'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_data  = {x_q, y_q};

endmodule

// File: tb/tb_simon64_128_decrypt.sv
// Self-checking bench for simon64_128_decrypt: vector table plus back-pressure,
// mid-operation reset, key-reuse and zero-vector sequences.
module tb_simon64_128_decrypt;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [0:63]  i_data = '0;
    logic [0:127] i_key = '0;
    logic         i_rekey = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [0:63]  o_data;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] STD_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  STD_CT  = 64'h44c8fc20_b9dfa07a;
    localparam logic [63:0]  STD_PT  = 64'h656b696c_20646e75;

    typedef struct {
        logic [127:0] key;
        logic [63:0]  ct;
        logic [63:0]  pt;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    simon64_128_decrypt dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_key   (i_key),
        .i_rekey (i_rekey),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    function automatic logic [31:0] ror(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Forward SIMON 64/128 reference used to build ciphertexts.
    function automatic logic [63:0] enc(input logic [127:0] key, input logic [63:0] pt);
        logic [31:0] k[44];
        logic [61:0] z;
        logic [31:0] t, x, y, tmp;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        k[0] = key[31:0];
        k[1] = key[63:32];
        k[2] = key[95:64];
        k[3] = key[127:96];
        for (int i = 0; i < 40; i++) begin
            t = ror(k[i+3], 3) ^ k[i+1];
            k[i+4] = 32'hFFFFFFFC ^ {31'b0, z[61-i]} ^ k[i] ^ t ^ ror(t, 1);
        end
        x = pt[63:32];
        y = pt[31:0];
        for (int i = 0; i < 44; i++) begin
            tmp = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic accept(input logic [127:0] key, input logic [63:0] ct, input logic rekey);
        int w = 0;
        while (!o_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        i_valid = 1'b1;
        i_data  = ct;
        i_key   = key;
        i_rekey = rekey;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must not matter.
        i_valid = 1'b0;
        i_data  = {$urandom, $urandom};
        i_key   = {$urandom, $urandom, $urandom, $urandom};
        i_rekey = 1'b0;
    endtask

    task automatic wait_done(output logic [63:0] pt, output int lat);
        logic rdy_seen = 1'b0;
        lat = 0;
        while (!o_valid && lat < 200) begin
            if (o_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check("ready_low_while_busy", {63'b0, rdy_seen}, 64'd0);
        pt = o_data;
    endtask

    task automatic release_done();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("idle_after_ready", {62'b0, o_valid, o_ready}, 64'd1);
    endtask

    task automatic run_block(input string tag, input logic [127:0] key, input logic [63:0] ct,
                             input logic rekey, input logic [63:0] exp_pt, input int exp_lat);
        logic [63:0] pt;
        int lat;
        accept(key, ct, rekey);
        wait_done(pt, lat);
        $display("%s: key=%h ct=%h rekey=%0d pt=%h lat=%0d", tag, key, ct, rekey, pt, lat);
        check({tag, "_pt"}, pt, exp_pt);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        release_done();
    endtask

    task automatic abort_at(input string tag, input int edges);
        logic seen = 1'b0;
        accept(STD_KEY, STD_CT, 1'b1);
        repeat (edges) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check({tag, "_ready_on_reset"}, {62'b0, o_valid, o_ready}, 64'd1);
        check({tag, "_data_on_reset"}, o_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) begin
            if (o_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        $display("%s: reset after %0d edges, valid_seen=%0d", tag, edges, seen);
        check({tag, "_no_output"}, {63'b0, seen}, 64'd0);
    endtask

    initial begin
        logic [63:0] pt, bp_pt;
        int lat;
        logic [63:0] zero_out;

        vecs[0] = '{STD_KEY, STD_CT, STD_PT};
        vecs[1].key = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        vecs[1].pt  = 64'h01234567_89abcdef;
        vecs[2].key = {128{1'b1}};
        vecs[2].pt  = 64'h0;
        vecs[3].key = 128'h01234567_89abcdef_fedcba98_76543210;
        vecs[3].pt  = 64'hdeadbeef_cafef00d;
        vecs[4].key = {$urandom, $urandom, $urandom, $urandom};
        vecs[4].pt  = {$urandom, $urandom};
        vecs[5].key = 128'h80000000_00000000_00000000_00000001;
        vecs[5].pt  = 64'hffffffff_ffffffff;
        for (int i = 1; i < 6; i++) vecs[i].ct = enc(vecs[i].key, vecs[i].pt);

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {62'b0, o_valid, o_ready}, 64'd1);
        check("reset_data", o_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, 1'b1, vecs[i].pt, 84);
        end

        // Back-pressure: DONE held with i_ready low, i_valid pulses ignored.
        accept(STD_KEY, STD_CT, 1'b1);
        wait_done(bp_pt, lat);
        check("bp_lat", 64'(lat), 64'd84);
        for (int c = 0; c < 20; c++) begin
            i_valid = c[0];
            i_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            check("bp_data", o_data, STD_PT);
            check("bp_flags", {62'b0, o_valid, o_ready}, 64'd2);
        end
        i_valid = 1'b0;
        $display("backpressure: held 20 cycles pt=%h", o_data);
        release_done();

        abort_at("rst_expand", 30);
        run_block("after_rst_expand", STD_KEY, STD_CT, 1'b0, STD_PT, 84);
        abort_at("rst_round", 60);
        run_block("after_rst_round", STD_KEY, STD_CT, 1'b0, STD_PT, 84);

`ifdef SIMON_DEC_KEY_CACHE_EN
        run_block("cache_hit", 128'h0, STD_CT, 1'b0, STD_PT, 44);
`else
        run_block("no_cache", STD_KEY, STD_CT, 1'b0, STD_PT, 84);
`endif
        run_block("rekey", vecs[3].key, vecs[3].ct, 1'b1, vecs[3].pt, 84);

        // Zero vector: re-encrypting the recovered plaintext must give zero.
        accept(128'h0, 64'h0, 1'b1);
        wait_done(pt, lat);
        zero_out = pt;
        $display("zero: key=0 ct=0 pt=%h lat=%0d", zero_out, lat);
        check("zero_lat", 64'(lat), 64'd84);
        check("zero_roundtrip", enc(128'h0, zero_out), 64'h0);
        rst = 1'b1;
        #1;
        check("zero_data_reset", o_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
